// File: rtl/keypad_scanner_pkg.sv
// Shared keypad constants: matrix geometry, FSM state codes, scan-result codes
// and the small row-decoding helpers used by the scanner.
package keypad_scanner_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] PRESSED  = 2'd2;
  localparam logic [1:0] RELEASE  = 2'd3;

  localparam logic [1:0] SCAN_NONE   = 2'd0;
  localparam logic [1:0] SCAN_SINGLE = 2'd1;
  localparam logic [1:0] SCAN_MULTI  = 2'd2;

  // Number of closed (low) rows, saturating at 2 since only 0/1/many matters.
  function automatic logic [1:0] count_closed(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] n;
    n = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!rows[r] && n != 2'd2) n = n + 2'd1;
    end
    return n;
  endfunction

  function automatic logic [1:0] first_closed(input logic [NUM_ROWS-1:0] rows);
    logic [1:0] idx;
    idx = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--) begin
      if (!rows[r]) idx = 2'(r);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Free-running divider: scan_tick is high for one clk every DIV cycles.
module scan_tick_gen #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic scan_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                 div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  assign scan_tick = (div_cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad reader: one-cold column scan, whole-scan debounce with
// ghost rejection, one-clk key_valid strobe and a held flag until release.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held
);

  localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

  logic              scan_tick;
  logic [NUM_ROWS-1:0] row_meta, row_sync;
  logic [1:0]        col_idx;
  logic [1:0]        acc_hits;
  logic [CODE_W-1:0] acc_code;
  logic [1:0]        state;
  logic [CODE_W-1:0] cand;
  logic [3:0]        cnt;

  logic [1:0]        col_hits, col_row, scan_hits, scan_res;
  logic [2:0]        hit_sum;
  logic [CODE_W-1:0] scan_code;
  logic [3:0]        cnt_inc;
  logic              scan_done, match;

  scan_tick_gen #(.DIV(CLK_HZ / SCAN_HZ)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .scan_tick (scan_tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
      assign col_out[gi] = (col_idx != 2'(gi));
    end
  endgenerate

  // Merge this column's sample with what the scan has seen so far.
  always_comb begin
    col_hits  = count_closed(row_sync);
    col_row   = first_closed(row_sync);
    hit_sum   = {1'b0, acc_hits} + {1'b0, col_hits};
    scan_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    scan_code = (acc_hits != 2'd0) ? acc_code : {col_row, col_idx};
    scan_res  = (scan_hits == 2'd0) ? SCAN_NONE :
                (scan_hits == 2'd1) ? SCAN_SINGLE : SCAN_MULTI;
    scan_done = scan_tick && (col_idx == 2'd3);
    match     = (scan_res == SCAN_SINGLE) && (scan_code == cand);
    cnt_inc   = (cnt < DB_N) ? cnt + 4'd1 : cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
      col_idx  <= '0;
      acc_hits <= '0;
      acc_code <= '0;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
      if (scan_tick) begin
        col_idx <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          acc_hits <= '0;
          acc_code <= '0;
        end else begin
          acc_hits <= scan_hits;
          acc_code <= scan_code;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (scan_res == SCAN_SINGLE) begin
              cand <= scan_code;
              cnt  <= 4'd1;
              if (DB_N == 4'd1) begin
                key_code  <= scan_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= PRESSED;
              end else begin
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (match) begin
              cnt <= cnt_inc;
              if (cnt_inc >= DB_N) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= PRESSED;
              end
            end else begin
              cnt   <= '0;
              state <= IDLE;
            end
          end
          PRESSED: begin
            if (!match) begin
              cnt   <= (scan_res == SCAN_NONE) ? 4'd1 : 4'd0;
              state <= RELEASE;
              if (scan_res == SCAN_NONE && DB_N == 4'd1) begin
                key_held <= 1'b0;
                state    <= IDLE;
              end
            end
          end
          default: begin
            // A different key while releasing restarts the release count.
            if (scan_res == SCAN_NONE) begin
              cnt <= cnt_inc;
              if (cnt_inc >= DB_N) begin
                key_held <= 1'b0;
                cnt      <= '0;
                state    <= IDLE;
              end
            end else if (match) begin
              state <= PRESSED;
            end else begin
              cnt <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule
